// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter and sequencer for the
// multiplexed external memory bus (address phase, then data phase held
// until b_rdy, then a one-cycle ack to the winning master).
// Master 0 is the CPU memory port; master 1 is the loader/debug requester.
// Optional data-phase watchdog: define BUS_ARB_TIMEOUT_EN to enable it.
// The external reset is synchronous and active-low.
module bus_arbiter #(
  parameter int AW      = 20,
  parameter int DW      = 64,
  parameter int TW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  input  logic [TW-1:0] m0_wtag,
  input  logic [TW-1:0] m1_wtag,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic          m_err,
  output logic [DW-1:0] m_rdata,
  output logic [TW-1:0] m_rtag,
  output logic [DW-1:0] b_ad,
  output logic [TW-1:0] b_tag,
  output logic          b_astb,
  output logic          b_rd,
  output logic          b_wr,
  input  logic [DW-1:0] b_data,
  input  logic [TW-1:0] b_itag,
  input  logic          b_rdy
);

  // The address is zero-extended onto b_ad; the watchdog needs a limit of at least one.
  if (AW > DW || TIMEOUT < 1) begin : g_param_check
    $error("bus_arbiter: AW must not exceed DW and TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  // grant: master owning the current transaction; last_grant: round-robin pointer
  logic grant, grant_nxt;
  logic last_grant, last_grant_nxt;
  logic latch_en;

  // Transaction request captured at grant time
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [TW-1:0] wtag_q;

  // Winner selection and its request fields
  logic          any_req;
  logic          win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [TW-1:0] sel_wtag;

  // Next values of the registered outputs
  logic          ack0_nxt, ack1_nxt;
  logic [DW-1:0] rdata_nxt;
  logic [TW-1:0] rtag_nxt;
  logic [DW-1:0] ad_nxt;
  logic [TW-1:0] tag_nxt;
  logic          astb_nxt, rd_nxt, wr_nxt;

  assign any_req = m0_req | m1_req;
  // Contention goes to the master that did not win last time; otherwise the sole requester.
  assign win       = (m0_req && m1_req) ? ~last_grant : m1_req;
  assign sel_we    = win ? m1_we    : m0_we;
  assign sel_addr  = win ? m1_addr  : m0_addr;
  assign sel_wdata = win ? m1_wdata : m0_wdata;
  assign sel_wtag  = win ? m1_wtag  : m0_wtag;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          limit_hit;
  logic          err_nxt;

  // Counts DATA cycles spent waiting on b_rdy; cleared whenever outside DATA.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state != DATA) begin
      wait_cnt <= '0;
    end else if (!b_rdy) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // This DATA cycle is the TIMEOUT-th one without ready.
  assign limit_hit = (wait_cnt == CW'(TIMEOUT - 1));
`endif

  // FSM state, current grant and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register sees
    // pre-edge values regardless of statement order.
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Capture the winner's request so later changes on the master ports are ignored.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath holding registers carry no reset; they are only read
    // after latch_en has loaded them.
    if (latch_en) begin
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      wtag_q  <= sel_wtag;
    end
  end

  // Next state and next registered-output values, derived from the state being entered.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    latch_en       = 1'b0;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    rdata_nxt      = '0;
    rtag_nxt       = '0;
    ad_nxt         = '0;
    tag_nxt        = '0;
    astb_nxt       = 1'b0;
    rd_nxt         = 1'b0;
    wr_nxt         = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    err_nxt        = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt      = ADDR;
          grant_nxt      = win;
          last_grant_nxt = win;
          latch_en       = 1'b1;
          astb_nxt       = 1'b1;
          ad_nxt         = DW'(sel_addr);
        end
      end

      ADDR: begin
        state_nxt = DATA;
        rd_nxt    = ~we_q;
        wr_nxt    = we_q;
        ad_nxt    = we_q ? wdata_q : '0;
        tag_nxt   = we_q ? wtag_q  : '0;
      end

      DATA: begin
        if (b_rdy) begin
          // Ready wins over a coincident watchdog limit.
          state_nxt = RESP;
          ack0_nxt  = ~grant;
          ack1_nxt  = grant;
          if (!we_q) begin
            rdata_nxt = b_data;
            rtag_nxt  = b_itag;
          end
`ifdef BUS_ARB_TIMEOUT_EN
        end else if (limit_hit) begin
          state_nxt = RESP;
          ack0_nxt  = ~grant;
          ack1_nxt  = grant;
          err_nxt   = 1'b1;
`endif
        end else begin
          // Hold the data phase stable while the memory side stalls.
          rd_nxt  = ~we_q;
          wr_nxt  = we_q;
          ad_nxt  = we_q ? wdata_q : '0;
          tag_nxt = we_q ? wtag_q  : '0;
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output registers: every master and bus output is driven from a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      m_rdata <= '0;
      m_rtag  <= '0;
      b_ad    <= '0;
      b_tag   <= '0;
      b_astb  <= 1'b0;
      b_rd    <= 1'b0;
      b_wr    <= 1'b0;
    end else begin
      m0_ack  <= ack0_nxt;
      m1_ack  <= ack1_nxt;
      m_rdata <= rdata_nxt;
      m_rtag  <= rtag_nxt;
      b_ad    <= ad_nxt;
      b_tag   <= tag_nxt;
      b_astb  <= astb_nxt;
      b_rd    <= rd_nxt;
      b_wr    <= wr_nxt;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  // Timeout flag register, valid alongside the ack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_err <= 1'b0;
    end else begin
      m_err <= err_nxt;
    end
  end
`else
  assign m_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench for bus_arbiter. Expected ack results are
// queued when a transaction is launched and compared when an ack appears.
module tb_bus_arbiter;

  localparam int AW = 20;
  localparam int DW = 64;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [TW-1:0] m0_wtag, m1_wtag;
  logic          m0_ack, m1_ack, m_err;
  logic [DW-1:0] m_rdata;
  logic [TW-1:0] m_rtag;
  logic [DW-1:0] b_ad;
  logic [TW-1:0] b_tag;
  logic          b_astb, b_rd, b_wr;
  logic [DW-1:0] b_data;
  logic [TW-1:0] b_itag;
  logic          b_rdy;

  always #5 clk = ~clk;

  bus_arbiter #(.AW(AW), .DW(DW), .TW(TW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_wtag(m0_wtag), .m1_wtag(m1_wtag),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m_err(m_err),
    .m_rdata(m_rdata), .m_rtag(m_rtag),
    .b_ad(b_ad), .b_tag(b_tag), .b_astb(b_astb), .b_rd(b_rd), .b_wr(b_wr),
    .b_data(b_data), .b_itag(b_itag), .b_rdy(b_rdy)
  );

  typedef struct {
    logic          master;
    logic [DW-1:0] rdata;
    logic [TW-1:0] rtag;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_txn(input logic m, input logic [DW-1:0] rd,
                            input logic [TW-1:0] rt, input logic e);
    exp_t x;
    x.master = m;
    x.rdata  = rd;
    x.rtag   = rt;
    x.err    = e;
    sb.push_back(x);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"},   {61'd0, b_astb, b_rd, b_wr}, 64'd0);
    chk({tag, "_ack"},   {61'd0, m0_ack, m1_ack, m_err}, 64'd0);
    chk({tag, "_ad"},    b_ad, 64'd0);
    chk({tag, "_tag"},   {56'd0, b_tag}, 64'd0);
    chk({tag, "_rdata"}, m_rdata, 64'd0);
    chk({tag, "_rtag"},  {56'd0, m_rtag}, 64'd0);
  endtask

  // Ack monitor: scoreboard pop/compare, single-ack rule, one-cycle pulse width.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_ack) begin
      chk("pulse_clear", {53'd0, m0_ack, m1_ack, m_err, m_rtag}, 64'd0);
      chk("pulse_clear_rdata", m_rdata, 64'd0);
    end
    if (m0_ack || m1_ack) begin
      chk("single_ack", {63'd0, m0_ack & m1_ack}, 64'd0);
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_ack: observed ack m0=%0b m1=%0b, expected no ack", m0_ack, m1_ack);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_master", {63'd0, m1_ack}, {63'd0, e.master});
        chk("sb_rdata",  m_rdata, e.rdata);
        chk("sb_rtag",   {56'd0, m_rtag}, {56'd0, e.rtag});
        chk("sb_err",    {63'd0, m_err}, {63'd0, e.err});
      end
    end
    prev_ack = m0_ack | m1_ack;
  end

  initial begin
    int acks;
    int astbs;
    bit got;
    logic exp_m;

    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_wtag = '0; m1_wtag = '0;
    b_data = '0; b_itag = '0; b_rdy = 1'b0;

    // Reset state
    repeat (3) step();
    chk_all_zero("reset");
    chk("reset_state", 64'(dut.state), 64'd0);
    reset = 1'b1;
    step();

    // Read from m0, ready on the first DATA cycle
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 20'h00123;
    b_data = 64'h0123456789ABCDEF; b_itag = 8'h35; b_rdy = 1'b1;
    expect_txn(1'b0, 64'h0123456789ABCDEF, 8'h35, 1'b0);
    step();
    chk("rd_astb", {63'd0, b_astb}, 64'd1);
    chk("rd_addr", b_ad, 64'h123);
    chk("rd_addr_tag", {56'd0, b_tag}, 64'd0);
    m0_addr = 20'h55555; m0_we = 1'b1;
    step();
    chk("rd_stroke", {61'd0, b_astb, b_rd, b_wr}, 64'b010);
    chk("rd_data_ad", b_ad, 64'd0);
    step();
    chk("rd_ack", {62'd0, m0_ack, m1_ack}, 64'b10);
    chk("rd_rdata", m_rdata, 64'h0123456789ABCDEF);
    chk("rd_rtag", {56'd0, m_rtag}, 64'h35);
    m0_req = 1'b0; m0_we = 1'b0; b_rdy = 1'b0;
    step();
    chk("rd_idle_astb", {63'd0, b_astb}, 64'd0);

    // Write from m1 with three wait states
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 20'h7FFFF;
    m1_wdata = 64'hFFFF0000FFFF0000; m1_wtag = 8'h12;
    b_data = 64'hDEADBEEFDEADBEEF; b_itag = 8'h77;
    expect_txn(1'b1, 64'd0, 8'h00, 1'b0);
    step();
    chk("wr_astb", {63'd0, b_astb}, 64'd1);
    chk("wr_addr", b_ad, 64'h7FFFF);
    m1_wdata = 64'h1111111111111111; m1_wtag = 8'h99; m1_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wr_stroke", {61'd0, b_astb, b_rd, b_wr}, 64'b001);
      chk("wr_ad", b_ad, 64'hFFFF0000FFFF0000);
      chk("wr_tag", {56'd0, b_tag}, 64'h12);
      if (i == 3) b_rdy = 1'b1;
    end
    step();
    chk("wr_ack", {62'd0, m0_ack, m1_ack}, 64'b01);
    chk("wr_rdata", m_rdata, 64'd0);
    m1_req = 1'b0; b_rdy = 1'b0;
    step();

    // Round robin with both masters requesting from reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = 20'h00001; m1_addr = 20'h00002; b_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_m  = k[0];
      b_data = 64'hC0DE000000000000 | 64'(k);
      b_itag = 8'hA0 + 8'(k);
      expect_txn(exp_m, b_data, b_itag, 1'b0);
      got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        step();
        if (m0_ack || m1_ack) got = 1'b1;
      end
      chk("rr_ack_seen", {63'd0, got}, 64'd1);
      chk("rr_grant", {63'd0, m1_ack}, {63'd0, exp_m});
      if (k == 3) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end else begin
        if (m0_ack) m0_req = 1'b0;
        if (m1_ack) m1_req = 1'b0;
        step();
        m0_req = 1'b1; m1_req = 1'b1;
      end
    end
    b_rdy = 1'b0;
    repeat (2) step();

    // Reset during the DATA wait of a read
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 20'h00ABC; b_rdy = 1'b0;
    repeat (3) step();
    chk("rst_pre_rd", {63'd0, b_rd}, 64'd1);
    reset = 1'b0;
    step();
    chk_all_zero("rst_mid");
    chk("rst_state", 64'(dut.state), 64'd0);
    reset = 1'b1; m0_req = 1'b0; b_rdy = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      acks += int'(m0_ack) + int'(m1_ack);
    end
    chk("rst_no_ack", 64'(acks), 64'd0);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 20'h00042;
    b_data = 64'h0000111122223333; b_itag = 8'h5A;
    expect_txn(1'b1, 64'h0000111122223333, 8'h5A, 1'b0);
    step();
    chk("post_rst_addr", b_ad, 64'h42);
    chk("post_rst_astb", {63'd0, b_astb}, 64'd1);
    step();
    chk("post_rst_rd", {63'd0, b_rd}, 64'd1);
    step();
    chk("post_rst_ack", {62'd0, m0_ack, m1_ack}, 64'b01);
    m1_req = 1'b0; b_rdy = 1'b0;
    step();

    // m0 withdraws its request during ADDR
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 20'h00777;
    m0_wdata = 64'h0F0F0F0F0F0F0F0F; m0_wtag = 8'h3C; b_rdy = 1'b1;
    expect_txn(1'b0, 64'd0, 8'h00, 1'b0);
    step();
    chk("wd_astb", {63'd0, b_astb}, 64'd1);
    m0_req = 1'b0;
    step();
    chk("wd_wr", {61'd0, b_astb, b_rd, b_wr}, 64'b001);
    chk("wd_ad", b_ad, 64'h0F0F0F0F0F0F0F0F);
    step();
    chk("wd_ack", {62'd0, m0_ack, m1_ack}, 64'b10);
    acks = 0; astbs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      acks  += int'(m0_ack) + int'(m1_ack);
      astbs += int'(b_astb);
    end
    chk("wd_no_ack", 64'(acks), 64'd0);
    chk("wd_no_grant", 64'(astbs), 64'd0);
    b_rdy = 1'b0;

`ifdef BUS_ARB_TIMEOUT_EN
    // Timeout after four DATA cycles without ready
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 20'h00100;
    b_data = 64'hBADBADBADBADBAD0; b_itag = 8'hEE;
    expect_txn(1'b0, 64'd0, 8'h00, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_wait_rd", {62'd0, b_rd, m0_ack}, 64'b10);
    end
    step();
    chk("to_ack", {62'd0, m0_ack, m_err}, 64'b11);
    chk("to_rdata", m_rdata, 64'd0);
    m0_req = 1'b0;
    step();

    // Ready in the fourth DATA cycle wins over the limit
    m0_req = 1'b1;
    b_data = 64'h5555AAAA5555AAAA; b_itag = 8'h66;
    expect_txn(1'b0, 64'h5555AAAA5555AAAA, 8'h66, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_race_rd", {63'd0, b_rd}, 64'd1);
      if (i == 3) b_rdy = 1'b1;
    end
    step();
    chk("to_race_ack", {62'd0, m0_ack, m_err}, 64'b10);
    chk("to_race_rdata", m_rdata, 64'h5555AAAA5555AAAA);
    m0_req = 1'b0; b_rdy = 1'b0;
    step();
`else
    // Without the watchdog the data phase waits indefinitely
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 20'h00100;
    b_data = 64'h5555AAAA5555AAAA; b_itag = 8'h66;
    expect_txn(1'b0, 64'h5555AAAA5555AAAA, 8'h66, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("long_wait", {61'd0, b_rd, m0_ack, m_err}, 64'b100);
    end
    b_rdy = 1'b1;
    step();
    chk("long_wait_ack", {62'd0, m0_ack, m_err}, 64'b10);
    m0_req = 1'b0; b_rdy = 1'b0;
    step();
`endif

    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
